inst_mem_server: RTL
====================

Name: inst_mem_server

Overview:
- Instruction-memory responder for the stepping processor core, which issues a word address and consumes the returned 8-bit instruction.
- Holds DEPTH instruction words and is filled by a byte-stream program loader through a valid/ready write port.
- After a full load it moves to RUN and serves read requests with fixed 1-cycle latency.
- Reads issued before the load completes return an error flag, not stale data.

Parameters:
DATA_W, 8, instruction word width
ADDR_W, 2, request address width
DEPTH, 4, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset
load_valid  in  1  loader offers load_data this cycle
load_data  in  DATA_W  instruction word to store
load_ready  out  1  block accepts a load word this cycle
load_done  out  1  one-cycle pulse when the final word of a load is accepted
reload  in  1  one-cycle request to restart loading from word 0
req_valid  in  1  processor read request
req_addr  in  ADDR_W  word address of the request
rsp_valid  out  1  response valid, exactly one cycle after req_valid
rsp_data  out  DATA_W  instruction returned
rsp_error  out  1  response invalid: not loaded, or address out of range
running  out  1  high in RUN state
wr_count  out  ADDR_W+1  number of words written in the current load

Behaviour:
Reset (reset low, asynchronous):
- State goes to LOAD.
- wr_count=0, load_done=0, rsp_valid=0, rsp_data=0, rsp_error=0, running=0.
- load_ready=1 once reset is released.
- Memory contents are not cleared.

States and transitions:
- LOAD: load_ready=1. A word is accepted when load_valid && load_ready: mem[wr_count] <= load_data, wr_count increments.
- LOAD -> RUN: on the accepting edge where wr_count==DEPTH-1. On that edge wr_count becomes DEPTH, load_done pulses high for exactly the next cycle, and load_ready is 0 from then on.
- RUN: load_ready=0, running=1. load_valid is ignored and memory is untouched.
- RUN -> LOAD: reload sampled high moves to LOAD with wr_count=0. Old contents stay readable only through error responses, i.e. not at all.
- reload in LOAD: wr_count is reset to 0. A load word accepted on the same edge is written to word 0 and wr_count becomes 1.

Read port:
- No back-pressure; one request per cycle sustained.
- req_valid at edge N gives rsp_valid=1 during cycle N+1.
- In RUN with req_addr < DEPTH: rsp_data=mem[req_addr], rsp_error=0.
- In RUN with req_addr >= DEPTH: rsp_data=0, rsp_error=1.
- In LOAD: rsp_data=0, rsp_error=1.
- With no request, rsp_valid=0 and rsp_data/rsp_error hold 0.

Simultaneous events:
- req_valid together with the final load word accepted: the request is evaluated in LOAD and the response is an error.
- req_valid together with reload in RUN: the request is served from current contents (no error), then the state is LOAD.

Width rule: addresses are never wrapped modulo DEPTH. An out-of-range address always produces an error response.

Reset mid-load: partially written words remain in memory, but wr_count=0 and the state is LOAD, so a complete reload is required before any read succeeds.

Test Plan:
1. Release reset, req_valid with addr 0 -> next cycle rsp_valid=1, rsp_error=1, rsp_data=0x00; running=0, load_ready=1.
2. Load 0x11,0x22,0x33,0x44 on consecutive cycles -> wr_count goes 1,2,3,4; load_done high exactly one cycle after the 0x44 edge; running=1; load_ready=0.
3. In RUN, back-to-back reads of addrs 3,0,2,1 -> responses 0x44,0x11,0x33,0x22 on the four following cycles, rsp_error=0 throughout.
4. DEPTH=3, ADDR_W=2, load 0xA0,0xA1,0xA2, read addr 3 -> rsp_error=1, rsp_data=0x00.
5. In RUN, assert reload with req addr 1 on the same cycle -> response 0x22 with no error; then running=0, wr_count=0, and the next read returns an error. Load 0x55 and hold load_valid -> stored at word 0.
6. Assert reset after 2 words of a load, release, read addr 0 -> error response. Then load 4 words and read them back correctly; load_valid asserted during RUN has no effect on memory.

Source files
------------

// File: rtl/inst_mem_server.sv
// Instruction memory filled by a byte-stream loader, then serving reads with 1-cycle latency.
// Loader is throttled by load_ready (low in RUN); the read port has no back-pressure.
module inst_mem_server #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    input  logic              reload_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_error_o,
    output logic              running_o,
    output logic [ADDR_W:0]   wr_count_o
);

    typedef enum logic {ST_LOAD, ST_RUN} state_e;

    localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic                load_done_q, load_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_error_q, rsp_error_d;
    logic [ADDR_W:0]     wr_base;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        load_done_d = 1'b0;
        mem_we      = 1'b0;
        wr_base     = wr_count_q;
        unique case (state_q)
            ST_LOAD: begin
                // A reload on the same edge as a load word restarts the fill at word 0.
                wr_base    = reload_i ? '0 : wr_count_q;
                wr_count_d = wr_base;
                if (load_valid_i) begin
                    mem_we     = 1'b1;
                    wr_count_d = wr_base + ONE;
                    if (wr_base == LAST) begin
                        state_d     = ST_RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (reload_i) begin
                    state_d    = ST_LOAD;
                    wr_count_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        mem_waddr = wr_base[ADDR_W-1:0];
    end

    // Requests are judged against the state before this edge's transition.
    always_comb begin
        rsp_valid_d = req_valid_i;
        rsp_data_d  = '0;
        rsp_error_d = 1'b0;
        if (req_valid_i) begin
            if (state_q == ST_RUN && {1'b0, req_addr_i} < DEPTH_V) begin
                rsp_data_d = mem[req_addr_i];
            end else begin
                rsp_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_LOAD;
            wr_count_q  <= '0;
            load_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            load_done_q <= load_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= load_data_i;
        end
    end

    assign load_ready_o = (state_q == ST_LOAD);
    assign running_o    = (state_q == ST_RUN);
    assign load_done_o  = load_done_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_error_o  = rsp_error_q;
    assign wr_count_o   = wr_count_q;

endmodule
